// File: rtl/branch_pkg.sv
// Shared types for the branch resolution slice: the in-flight branch record,
// the controller state encoding and the fixed instruction size.
package branch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] PC;
        logic        pred;
        logic [31:0] addr;
    } br_rec_t;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/br_fifo.sv
// In-order FIFO of predicted-branch records. Clear empties it in one cycle and
// takes priority over any same-cycle push or pop.
module br_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  br_rec_t                  wdata,
    output br_rec_t                  head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    br_rec_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push = push && (count_q != FULL_CNT);
        do_pop  = pop && (count_q != '0);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers are AW bits wide, so wrap-around modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted branches in order, checks each resolution against its
// prediction, and issues a one-cycle flush/redirect plus predictor training.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [31:0] push_PC,
    input  logic        push_pred,
    input  logic [31:0] push_addr,
    input  logic        res_valid,
    input  logic [31:0] res_PC,
    input  logic        res_taken,
    input  logic [31:0] res_addr,
    input  logic        flush_in,
    output logic        flush,
    output logic [31:0] redirect_addr,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic        err,
    output logic [31:0] cnt_branch,
    output logic [31:0] cnt_mispred
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t        state_q;
    logic          flush_q, upd_valid_q, upd_taken_q, err_q;
    logic [31:0]   redirect_q, cnt_branch_q, cnt_mispred_q;

    br_rec_t       head, wrec;
    logic [CW-1:0] count;
    logic          res_ok, res_bad, mispred, push_fire;
    logic          fifo_clear, fifo_push, fifo_pop;

    always_comb begin
        push_ready = (state_q == RUN) && (count < FULL_CNT);
        push_fire  = push_valid && push_ready;
        res_ok     = res_valid && (count != '0) && (res_PC == head.PC);
        res_bad    = res_valid && !res_ok;
        mispred    = res_ok && ((head.pred != res_taken) ||
                                (head.pred && res_taken && (head.addr != res_addr)));
        fifo_clear = flush_in || mispred;
        fifo_push  = push_fire && !fifo_clear;
        fifo_pop   = res_ok && !fifo_clear;
        wrec       = '{PC: push_PC, pred: push_pred, addr: push_addr};
    end

    br_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wrec),
        .head  (head),
        .count (count)
    );

    // External flush discards the resolve entirely, so neither err nor the
    // counters may move in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            err_q         <= 1'b0;
            cnt_branch_q  <= '0;
            cnt_mispred_q <= '0;
        end else if (flush_in) begin
            state_q     <= RUN;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
        end else begin
            state_q     <= mispred ? FLUSH : RUN;
            flush_q     <= mispred;
            redirect_q  <= !mispred ? '0 :
                           (res_taken ? res_addr : res_PC + 32'(INSTR_BYTES));
            upd_valid_q <= res_ok;
            upd_taken_q <= res_ok && res_taken;
            if (res_bad) err_q <= 1'b1;
            if (res_ok && (cnt_branch_q != '1))  cnt_branch_q  <= cnt_branch_q + 1'b1;
            if (mispred && (cnt_mispred_q != '1)) cnt_mispred_q <= cnt_mispred_q + 1'b1;
        end
    end

    assign flush         = flush_q;
    assign redirect_addr = redirect_q;
    assign upd_valid     = upd_valid_q;
    assign upd_taken     = upd_taken_q;
    assign err           = err_q;
    assign cnt_branch    = cnt_branch_q;
    assign cnt_mispred   = cnt_mispred_q;

endmodule
